// File: rtl/tlul_sram_slave_if.sv
// TL-UL A/D channel bundle between a TL-UL master and the SRAM slave endpoint.
// Both channels transfer on a rising clk_24 edge where valid&ready; a sender holds its fields stable from valid until that edge.
interface tlul_sram_slave_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3,
    parameter int SIZE_WIDTH   = 3,
    parameter int SRC_WIDTH    = 1,
    parameter int SINK_WIDTH   = 1
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                    a_valid;
    logic                    a_ready;
    logic [OPCODE_WIDTH-1:0] a_opcode;
    logic [PARAM_WIDTH-1:0]  a_param;
    logic [SIZE_WIDTH-1:0]   a_size;
    logic [SRC_WIDTH-1:0]    a_source;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [MASK_WIDTH-1:0]   a_mask;
    logic [DATA_WIDTH-1:0]   a_data;

    logic                    d_valid;
    logic                    d_ready;
    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [PARAM_WIDTH-1:0]  d_param;
    logic [SIZE_WIDTH-1:0]   d_size;
    logic [SRC_WIDTH-1:0]    d_source;
    logic [SINK_WIDTH-1:0]   d_sink;
    logic [DATA_WIDTH-1:0]   d_data;
    logic                    d_error;

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        input  d_ready
    );

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        output d_ready
    );
endinterface

// File: rtl/tlul_sram_slave.sv
// TL-UL slave serving Get/PutFullData/PutPartialData from a small word memory,
// one transaction at a time, with a fixed accept-to-response latency.
module tlul_sram_slave #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    SRC_WIDTH    = 1,
    parameter int                    SINK_WIDTH   = 1,
    parameter int                    DEPTH        = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h0000_1000),
    parameter int                    RESP_LATENCY = 2
) (
    input  logic             clk_24,
    input  logic             reset,
    tlul_sram_slave_if.slave bus,
    output logic [1:0]       o_dbg_state
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int MASK_LOG   = $clog2(MASK_WIDTH);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(RESP_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [OPCODE_WIDTH-1:0] r_d_opcode;
    logic [SIZE_WIDTH-1:0]   r_d_size;
    logic [SRC_WIDTH-1:0]    r_d_source;
    logic [DATA_WIDTH-1:0]   r_d_data;
    logic                    r_d_error;

    logic                    w_accept;
    logic                    w_is_get;
    logic                    w_is_put;
    logic                    w_op_ok;
    logic                    w_size_ok;
    logic                    w_align_ok;
    logic                    w_range_ok;
    logic                    w_err;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic [IDX_W-1:0]        w_idx;
    logic [MASK_LOG-1:0]     w_low_mask;
    logic                    w_unused;

    assign w_accept   = bus.a_valid && (r_state == ST_IDLE);
    assign w_is_get   = (bus.a_opcode == OPCODE_WIDTH'(4));
    assign w_is_put   = (bus.a_opcode == OPCODE_WIDTH'(0)) || (bus.a_opcode == OPCODE_WIDTH'(1));
    assign w_op_ok    = w_is_get || w_is_put;
    assign w_size_ok  = (bus.a_size <= SIZE_WIDTH'(MASK_LOG));

    // Low address bits that must be zero for a 2^a_size access.
    always_comb begin
        w_low_mask = '0;
        for (int i = 0; i < MASK_LOG; i++) begin
            w_low_mask[i] = (SIZE_WIDTH'(i) < bus.a_size);
        end
    end

    assign w_align_ok = ~|(bus.a_address[MASK_LOG-1:0] & w_low_mask);
    assign w_offset   = bus.a_address - BASE_ADDR;
    assign w_range_ok = (bus.a_address >= BASE_ADDR) && (w_offset < SPAN);
    assign w_idx      = w_offset[IDX_W+1:2];
    assign w_err      = !(w_op_ok && w_size_ok && w_align_ok && w_range_ok);
    assign w_unused   = ^bus.a_param;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.a_valid) w_next_state = (RESP_LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == CNT_W'(1)) w_next_state = ST_RESP;
            ST_RESP: if (bus.d_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_24 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= CNT_W'(RESP_LATENCY - 1);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Response fields are frozen at accept, so they stay stable through any D stall.
    always_ff @(posedge clk_24 or negedge reset) begin
        if (!reset) begin
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_data   <= '0;
            r_d_error  <= 1'b0;
        end else if (w_accept) begin
            r_d_opcode <= w_is_get ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0);
            r_d_size   <= bus.a_size;
            r_d_source <= bus.a_source;
            r_d_data   <= (w_is_get && !w_err) ? r_mem[w_idx] : '0;
            r_d_error  <= w_err;
        end
    end

    always_ff @(posedge clk_24 or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                r_mem[w] <= '0;
            end
        end else if (w_accept && w_is_put && !w_err) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (bus.a_mask[i]) r_mem[w_idx][i*8 +: 8] <= bus.a_data[i*8 +: 8];
            end
        end
    end

    assign bus.a_ready    = (r_state == ST_IDLE);
    assign bus.d_valid    = (r_state == ST_RESP);
    assign bus.d_opcode   = r_d_opcode;
    assign bus.d_param    = '0;
    assign bus.d_size     = r_d_size;
    assign bus.d_source   = r_d_source;
    assign bus.d_sink     = '0;
    assign bus.d_data     = r_d_data;
    assign bus.d_error    = r_d_error;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_tlul_sram_slave.sv
// Bench for tlul_sram_slave: directed scenarios plus random traffic against a
// byte-addressed reference memory.
module tb_tlul_sram_slave;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          LAT   = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad   = 0;

    logic [7:0]  model_b [DEPTH*4];
    logic [31:0] exp_q [$];

    tlul_sram_slave_if bus_if ();

    tlul_sram_slave #(
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .RESP_LATENCY(LAT)
    ) dut (
        .clk_24     (clk),
        .reset      (rst_n),
        .bus        (bus_if),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [2:0] op, input logic [2:0] size, input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
        if (size > 3'd2) return 1'b1;
        if ((a % (longint'(1) << size)) != 0) return 1'b1;
        if (a < longint'(BASE) || a >= longint'(BASE) + DEPTH * 4) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH * 4; i++) model_b[i] = 8'h00;
    endtask

    task automatic drive_noise();
        bus_if.a_valid   = 1'($urandom_range(0, 1));
        bus_if.a_opcode  = 3'($urandom_range(0, 7));
        bus_if.a_size    = 3'($urandom_range(0, 7));
        bus_if.a_source  = 1'($urandom_range(0, 1));
        bus_if.a_address = BASE + 32'($urandom_range(0, 63));
        bus_if.a_mask    = 4'($urandom_range(0, 15));
        bus_if.a_data    = $urandom;
    endtask

    task automatic check_d(input string tag, input logic [2:0] eop, input logic [2:0] esz,
                           input logic esrc, input logic [31:0] edata, input logic eerr);
        check({tag, ".d_valid"},  32'(bus_if.d_valid),  32'd1);
        check({tag, ".d_opcode"}, 32'(bus_if.d_opcode), 32'(eop));
        check({tag, ".d_size"},   32'(bus_if.d_size),   32'(esz));
        check({tag, ".d_source"}, 32'(bus_if.d_source), 32'(esrc));
        check({tag, ".d_data"},   bus_if.d_data,        edata);
        check({tag, ".d_error"},  32'(bus_if.d_error),  32'(eerr));
        check({tag, ".d_param"},  32'(bus_if.d_param),  32'd0);
        check({tag, ".d_sink"},   32'(bus_if.d_sink),   32'd0);
    endtask

    // One full A->D transaction; the model decides every expected response field.
    task automatic do_txn(input string tag, input logic [2:0] op, input logic [2:0] size,
                          input logic src, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input int hold, input bit noise);
        bit          eerr;
        logic [2:0]  eop;
        logic [31:0] edata;
        int          off;
        int          cyc;

        eerr  = model_err(op, size, addr);
        eop   = (op == 3'd4) ? 3'd1 : 3'd0;
        edata = 32'h0;
        off   = int'((addr - BASE) & 32'hFFFF_FFFC);
        if (!eerr && op == 3'd4) begin
            edata = {model_b[off+3], model_b[off+2], model_b[off+1], model_b[off]};
        end else if (!eerr) begin
            for (int i = 0; i < 4; i++) if (mask[i]) model_b[off+i] = data[i*8 +: 8];
        end
        exp_q.push_back(edata);

        @(negedge clk);
        bus_if.a_valid   = 1'b1;
        bus_if.a_opcode  = op;
        bus_if.a_param   = 3'($urandom_range(0, 7));
        bus_if.a_size    = size;
        bus_if.a_source  = src;
        bus_if.a_address = addr;
        bus_if.a_mask    = mask;
        bus_if.a_data    = data;
        check({tag, ".a_ready_idle"}, 32'(bus_if.a_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_if.a_valid = 1'b0;

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, ".a_ready_busy"}, 32'(bus_if.a_ready), 32'd0);
            if (noise) drive_noise();
        end while (!bus_if.d_valid && cyc < 20);
        check({tag, ".latency"}, 32'(cyc), 32'(LAT));
        edata = exp_q.pop_front();

        for (int h = 0; h < hold; h++) begin
            check_d({tag, ".stall"}, eop, size, src, edata, eerr);
            check({tag, ".a_ready_stall"}, 32'(bus_if.a_ready), 32'd0);
            @(negedge clk);
            if (noise) drive_noise();
        end

        bus_if.a_valid = 1'b0;
        bus_if.d_ready = 1'b1;
        check_d(tag, eop, size, src, edata, eerr);
        @(posedge clk);
        #1;
        bus_if.d_ready = 1'b0;
        @(negedge clk);
        check({tag, ".a_ready_after"}, 32'(bus_if.a_ready), 32'd1);
        check({tag, ".d_valid_after"}, 32'(bus_if.d_valid), 32'd0);
    endtask

    initial begin
        int          r;
        logic [2:0]  op;
        logic [2:0]  size;
        logic [31:0] addr;

        bus_if.a_valid   = 1'b0;
        bus_if.a_opcode  = 3'd0;
        bus_if.a_param   = 3'd0;
        bus_if.a_size    = 3'd0;
        bus_if.a_source  = 1'b0;
        bus_if.a_address = 32'h0;
        bus_if.a_mask    = 4'h0;
        bus_if.a_data    = 32'h0;
        bus_if.d_ready   = 1'b0;
        model_clear();

        // Reset state
        rst_n = 1'b0;
        #23;
        check("reset.a_ready",  32'(bus_if.a_ready),  32'd1);
        check("reset.d_valid",  32'(bus_if.d_valid),  32'd0);
        check("reset.d_opcode", 32'(bus_if.d_opcode), 32'd0);
        check("reset.d_data",   bus_if.d_data,        32'd0);
        check("reset.d_error",  32'(bus_if.d_error),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        do_txn("put_full", 3'd0, 3'd2, 1'b1, 32'h1004, 4'hF, 32'hA5A5_A5A5, 0, 1'b0);
        do_txn("get_full", 3'd4, 3'd2, 1'b0, 32'h1004, 4'hF, 32'h0,         0, 1'b0);
        do_txn("put_part", 3'd1, 3'd2, 1'b1, 32'h1004, 4'h3, 32'h0000_1234, 0, 1'b0);
        do_txn("get_part", 3'd4, 3'd2, 1'b1, 32'h1004, 4'h0, 32'h0,         1, 1'b0);
        do_txn("get_oor",  3'd4, 3'd2, 1'b0, 32'h2000, 4'hF, 32'h0,         0, 1'b0);
        do_txn("put_oor",  3'd0, 3'd2, 1'b0, 32'h2000, 4'hF, 32'hFFFF_FFFF, 0, 1'b0);
        for (int w = 0; w < DEPTH; w++) begin
            do_txn("sweep", 3'd4, 3'd2, 1'(w), BASE + 32'(w * 4), 4'hF, 32'h0, 0, 1'b0);
        end
        do_txn("bad_op",   3'd2, 3'd2, 1'b1, 32'h1008, 4'hF, 32'h1111_2222, 0, 1'b0);
        do_txn("bad_size", 3'd0, 3'd3, 1'b0, 32'h1008, 4'hF, 32'h3333_4444, 0, 1'b0);
        do_txn("misalign", 3'd0, 3'd2, 1'b0, 32'h100A, 4'hF, 32'h5555_6666, 0, 1'b0);
        do_txn("below",    3'd4, 3'd2, 1'b0, 32'h0FFC, 4'hF, 32'h0,         0, 1'b0);
        do_txn("top_word", 3'd0, 3'd2, 1'b1, 32'h103C, 4'hC, 32'hBEEF_0000, 0, 1'b0);
        do_txn("top_get",  3'd4, 3'd2, 1'b1, 32'h103C, 4'hF, 32'h0,         0, 1'b0);
        do_txn("byte_ok",  3'd1, 3'd0, 1'b0, 32'h1013, 4'h8, 32'h7700_0000, 0, 1'b0);
        do_txn("stall5",   3'd4, 3'd0, 1'b1, 32'h1013, 4'hF, 32'h0,         5, 1'b1);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      op = 3'd4;
            else if (r < 7) op = 3'd0;
            else if (r < 9) op = 3'd1;
            else            op = 3'($urandom_range(0, 7));
            size = ($urandom_range(0, 9) < 7) ? 3'd2 : 3'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            else addr = BASE - 32'd8 + 32'($urandom_range(0, DEPTH * 4 + 15));
            do_txn("rand", op, size, 1'($urandom_range(0, 1)), addr,
                   4'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset while a Put is waiting for its response
        @(negedge clk);
        bus_if.a_valid   = 1'b1;
        bus_if.a_opcode  = 3'd0;
        bus_if.a_size    = 3'd2;
        bus_if.a_address = 32'h1008;
        bus_if.a_mask    = 4'hF;
        bus_if.a_data    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus_if.a_valid = 1'b0;
        @(negedge clk);
        check("rst_wait.a_ready", 32'(bus_if.a_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        check("rst_async.a_ready", 32'(bus_if.a_ready), 32'd1);
        check("rst_async.d_valid", 32'(bus_if.d_valid), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst_drop.d_valid", 32'(bus_if.d_valid), 32'd0);
        end
        check("rst_drop.a_ready", 32'(bus_if.a_ready), 32'd1);
        do_txn("rst_get8", 3'd4, 3'd2, 1'b0, 32'h1008, 4'hF, 32'h0, 0, 1'b0);
        do_txn("rst_get4", 3'd4, 3'd2, 1'b1, 32'h1004, 4'hF, 32'h0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
